// File: rtl/pipe_divider.sv
// pipe_divider: WIDTH-stage restoring divider, one op/clk, valid/ready, signed option, div-by-zero flag, tag passthrough
module pipe_divider #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter bit SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_zero,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH:0] pr [WIDTH];
  logic [WIDTH:0] npr [WIDTH];
  logic [WIDTH-1:0] dq [WIDTH];
  logic [WIDTH-1:0] ndq [WIDTH];
  logic [WIDTH-1:0] d [WIDTH];
  logic [TAG_W-1:0] tg [WIDTH];
  logic [WIDTH-1:0] v, sx, sy, dz;
  logic adv, xn, yn;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign xn = SIGNED && x[WIDTH-1];
  assign yn = SIGNED && y[WIDTH-1];
  genvar k;
  generate
    for (k = 0; k < WIDTH; k++) begin : g_step
      logic [WIDTH+1:0] sh, diff;
      always_comb begin
        sh = {pr[k], dq[k][WIDTH-1]};
        diff = sh - (WIDTH+2)'(d[k]);
        npr[k] = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
        ndq[k] = {dq[k][WIDTH-2:0], !diff[WIDTH+1]};
      end
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      out_valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      tag_out <= '0;
      div_zero <= 1'b0;
    end else if (adv) begin
      v <= {v[WIDTH-2:0], in_valid};
      sx <= {sx[WIDTH-2:0], xn};
      sy <= {sy[WIDTH-2:0], yn};
      dz <= {dz[WIDTH-2:0], y == '0};
      pr[0] <= '0;
      dq[0] <= xn ? -x : x;
      d[0] <= yn ? -y : y;
      tg[0] <= tag_in;
      for (int i = 1; i < WIDTH; i++) begin
        pr[i] <= npr[i-1];
        dq[i] <= ndq[i-1];
        d[i] <= d[i-1];
        tg[i] <= tg[i-1];
      end
      out_valid <= v[WIDTH-1];
      quotient <= dz[WIDTH-1] ? '1 : (sx[WIDTH-1] ^ sy[WIDTH-1]) ? -ndq[WIDTH-1] : ndq[WIDTH-1];
      remainder <= sx[WIDTH-1] ? -WIDTH'(npr[WIDTH-1]) : WIDTH'(npr[WIDTH-1]);
      tag_out <= tg[WIDTH-1];
      div_zero <= dz[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_pipe_divider.sv
// tb_pipe_divider: scoreboard bench for unsigned W8, signed W8 and unsigned W16 dividers
module tb_pipe_divider;
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic [3:0] tag;
    logic dz;
  } res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] xi [3];
  logic [15:0] yi [3];
  logic [3:0] ti [3];
  logic iv [3];
  logic ordy [3];
  logic ir_a, ov_a, dz_a, ir_s, ov_s, dz_s, ir_h, ov_h, dz_h;
  logic [7:0] q_a, r_a, q_s, r_s;
  logic [15:0] q_h, r_h;
  logic [3:0] t_a, t_s, t_h;
  res_t sb [3][$];
  res_t prev [3];
  bit hold [3];
  bit acc [3];
  int n_out [3];
  int n_cmp = 0;
  int n_bad = 0;
  bit bp = 1'b0;
  pipe_divider #(.WIDTH(8), .TAG_W(4), .SIGNED(0)) u_a (
    .clk(clk), .reset(reset), .x(xi[0][7:0]), .y(yi[0][7:0]), .tag_in(ti[0]),
    .in_valid(iv[0]), .in_ready(ir_a), .quotient(q_a), .remainder(r_a),
    .tag_out(t_a), .div_zero(dz_a), .out_valid(ov_a), .out_ready(ordy[0]));
  pipe_divider #(.WIDTH(8), .TAG_W(4), .SIGNED(1)) u_s (
    .clk(clk), .reset(reset), .x(xi[1][7:0]), .y(yi[1][7:0]), .tag_in(ti[1]),
    .in_valid(iv[1]), .in_ready(ir_s), .quotient(q_s), .remainder(r_s),
    .tag_out(t_s), .div_zero(dz_s), .out_valid(ov_s), .out_ready(ordy[1]));
  pipe_divider #(.WIDTH(16), .TAG_W(4), .SIGNED(0)) u_h (
    .clk(clk), .reset(reset), .x(xi[2]), .y(yi[2]), .tag_in(ti[2]),
    .in_valid(iv[2]), .in_ready(ir_h), .quotient(q_h), .remainder(r_h),
    .tag_out(t_h), .div_zero(dz_h), .out_valid(ov_h), .out_ready(ordy[2]));
  function automatic res_t model(input int i, input logic [15:0] x, input logic [15:0] y, input logic [3:0] t);
    res_t e;
    int w, m, xs, ys, q, r;
    w = (i == 2) ? 16 : 8;
    m = (1 << w) - 1;
    xs = int'(x) & m;
    ys = int'(y) & m;
    if (i == 1) begin
      if (xs >= (1 << (w - 1))) xs -= (1 << w);
      if (ys >= (1 << (w - 1))) ys -= (1 << w);
    end
    if (ys == 0) begin
      q = m;
      r = xs;
    end else begin
      q = xs / ys;
      r = xs % ys;
    end
    e.q = 16'(q & m);
    e.r = 16'(r & m);
    e.tag = t;
    e.dz = (ys == 0);
    return e;
  endfunction
  task automatic chk(input string t, input int i, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", t, i, o, e);
    end
  endtask
  task automatic mon(input int i, input logic ov, input logic ir, input logic [15:0] q, input logic [15:0] r, input logic [3:0] tg, input logic dz);
    res_t cur, e;
    cur = {q, r, tg, dz};
    chk("in_ready", i, 64'(ir), 64'(!ov | ordy[i]));
    if (hold[i]) chk("hold", i, {ov, cur}, {1'b1, prev[i]});
    if (ov) begin
      if (sb[i].size() == 0) chk("spurious_out", i, 64'(ov), 64'(0));
      else if (ordy[i]) begin
        e = sb[i].pop_front();
        chk("result", i, 64'(cur), 64'(e));
        n_out[i]++;
      end
    end
    hold[i] = ov && !ordy[i];
    prev[i] = cur;
    acc[i] = !reset && iv[i] && ir;
    if (acc[i]) sb[i].push_back(model(i, xi[i], yi[i], ti[i]));
    if (reset) begin
      sb[i].delete();
      hold[i] = 1'b0;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    mon(0, ov_a, ir_a, 16'(q_a), 16'(r_a), t_a, dz_a);
    mon(1, ov_s, ir_s, 16'(q_s), 16'(r_s), t_s, dz_s);
    mon(2, ov_h, ir_h, q_h, r_h, t_h, dz_h);
    @(posedge clk);
    #1;
    if (bp) ordy[0] = 1'($urandom_range(0, 1));
  endtask
  task automatic put(input int i, input logic [15:0] x, input logic [15:0] y, input logic [3:0] t);
    int k;
    xi[i] = x;
    yi[i] = y;
    ti[i] = t;
    iv[i] = 1'b1;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!acc[i] && k < 100);
    chk("accept", i, 64'(acc[i]), 64'(1));
    iv[i] = 1'b0;
  endtask
  task automatic drain(input int i);
    int k;
    bp = 1'b0;
    ordy[i] = 1'b1;
    k = 0;
    while (sb[i].size() > 0 && k < 200) begin
      cyc();
      k++;
    end
    cyc();
    chk("drain", i, 64'(sb[i].size()), 64'(0));
  endtask
  initial begin
    int n, base;
    for (int i = 0; i < 3; i++) begin
      xi[i] = '0;
      yi[i] = '0;
      ti[i] = '0;
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      n_out[i] = 0;
    end
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_out_valid", 0, 64'(ov_a), 64'(0));
    chk("rst_quotient", 0, 64'(q_a), 64'(0));
    chk("rst_remainder", 0, 64'(r_a), 64'(0));
    chk("rst_tag_dz", 0, 64'({t_a, dz_a}), 64'(0));
    chk("rst_in_ready", 0, 64'(ir_a), 64'(1));
    put(0, 8, 13, 3);
    n = 1;
    while (!ov_a && n < 40) begin
      cyc();
      n++;
    end
    chk("latency", 0, 64'(n), 64'(9));
    chk("first_result", 0, 64'({q_a, r_a, t_a, dz_a}), 64'({8'd0, 8'd8, 4'd3, 1'b0}));
    cyc();
    chk("valid_drop", 0, 64'(ov_a), 64'(0));
    put(0, 200, 7, 0);
    put(0, 255, 1, 1);
    put(0, 13, 5, 2);
    put(0, 0, 9, 3);
    n = 0;
    while (!ov_a && n < 40) begin
      cyc();
      n++;
    end
    for (int j = 0; j < 4; j++) begin
      chk("b2b_valid", j, 64'(ov_a), 64'(1));
      cyc();
    end
    chk("b2b_end", 0, 64'(ov_a), 64'(0));
    put(0, 5, 2, 1);
    put(0, 77, 0, 2);
    put(0, 100, 3, 3);
    drain(0);
    base = n_out[0];
    bp = 1'b1;
    for (int j = 0; j < 12; j++)
      put(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 15)), 4'(j));
    for (int j = 0; j < 6; j++) cyc();
    drain(0);
    chk("bp_count", 0, 64'(n_out[0] - base), 64'(12));
    put(1, 16'h00F9, 16'h0002, 1);
    put(1, 16'h0007, 16'h00FE, 2);
    put(1, 16'h0080, 16'h00FF, 3);
    put(1, 16'h0080, 16'h0000, 4);
    put(1, 16'h0064, 16'h00F9, 5);
    drain(1);
    base = n_out[0];
    put(0, 90, 4, 5);
    put(0, 91, 5, 6);
    put(0, 92, 6, 7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int j = 0; j < 15; j++) begin
      chk("post_reset_idle", j, 64'(ov_a), 64'(0));
      cyc();
    end
    put(0, 50, 6, 9);
    drain(0);
    chk("post_reset_count", 0, 64'(n_out[0] - base), 64'(1));
    put(2, 200, 7, 0);
    put(2, 255, 1, 1);
    put(2, 13, 5, 2);
    put(2, 0, 9, 3);
    put(2, 60000, 300, 4);
    put(2, 65535, 0, 5);
    drain(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
